pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for flow-controlled pipeline stage registers: state
// encoding, occupancy width and per-boundary field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned OCC_W = 2;

  // Field widths per inter-stage boundary; stage decode/pack logic uses the same values.
  localparam int unsigned FD_CTRL_W = 8;
  localparam int unsigned FD_DATA_W = 64;
  localparam int unsigned DE_CTRL_W = 24;
  localparam int unsigned DE_DATA_W = 128;
  localparam int unsigned EM_CTRL_W = 16;
  localparam int unsigned EM_DATA_W = 96;
  localparam int unsigned MW_CTRL_W = 8;
  localparam int unsigned MW_DATA_W = 64;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    logic [OCC_W-1:0] n;
    n = '0;
    case (s)
      BUSY:    n = 2'd1;
      FULL:    n = 2'd2;
      default: n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush and an optional
// skid entry that makes InReady a registered signal.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SKID   = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               CLR,
  input  logic               InValid,
  output logic               InReady,
  input  logic [CTRL_W-1:0]  InCtrl,
  input  logic [DATA_W-1:0]  InData,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [CTRL_W-1:0]  OutCtrl,
  output logic [DATA_W-1:0]  OutData,
  output logic [OCC_W-1:0]   Occupancy
);

  pipe_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl;
  logic [DATA_W-1:0] main_data_q, skid_data;
  logic              in_fire, out_fire;
  logic              load_in, load_from_skid, load_skid, drain;

  assign OutValid  = (state_q != EMPTY);
  assign OutCtrl   = main_ctrl_q;
  assign OutData   = main_data_q;
  assign Occupancy = occ_of(state_q);
  assign in_fire   = InValid & InReady;
  assign out_fire  = OutValid & OutReady;

  always_comb begin
    state_d        = state_q;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    drain          = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_in = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_in = 1'b1;
        end else if (in_fire && (SKID != 0)) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          drain   = 1'b1;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (CLR) state_d = EMPTY;
  end

  // Control is zeroed on drain as well as flush so an empty stage is always a bubble.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (CLR) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_in) begin
        main_ctrl_q <= InCtrl;
        main_data_q <= InData;
      end else if (load_from_skid) begin
        main_ctrl_q <= skid_ctrl;
        main_data_q <= skid_data;
      end else if (drain) begin
        main_ctrl_q <= '0;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] ctrl_q;
      logic [DATA_W-1:0] data_q;
      logic              ready_q;

      // Ready is registered from the next state, so the upstream sees no combinational path.
      always_ff @(posedge CLK) begin
        if (Reset) begin
          ctrl_q  <= '0;
          data_q  <= '0;
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != FULL);
          if (CLR) begin
            ctrl_q <= '0;
          end else if (load_skid) begin
            ctrl_q <= InCtrl;
            data_q <= InData;
          end else if (load_from_skid) begin
            ctrl_q <= '0;
          end
        end
      end

      assign skid_ctrl = ctrl_q;
      assign skid_data = data_q;
      assign InReady   = ready_q;
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign InReady   = OutReady | ~OutValid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboarded checks of pipe_stage_reg with and without the skid entry.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr1, iv1, or1, ir1, ov1;
  logic [7:0]  ic1, oc1;
  logic [15:0] id1, od1;
  logic [1:0]  occ1;
  logic clr0, iv0, or0, ir0, ov0;
  logic [7:0]  ic0, oc0;
  logic [15:0] id0, od0;
  logic [1:0]  occ0;

  int tests  = 0;
  int failed = 0;

  logic [27:0] obs1, obs0;
  assign obs1 = {ov1, oc1, od1, occ1, ir1};
  assign obs0 = {ov0, oc0, od0, occ0, ir0};

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } ent_t;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1)) u1 (
    .CLK(clk), .Reset(rst), .CLR(clr1), .InValid(iv1), .InReady(ir1),
    .InCtrl(ic1), .InData(id1), .OutValid(ov1), .OutReady(or1),
    .OutCtrl(oc1), .OutData(od1), .Occupancy(occ1)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0)) u0 (
    .CLK(clk), .Reset(rst), .CLR(clr0), .InValid(iv0), .InReady(ir0),
    .InCtrl(ic0), .InData(id0), .OutValid(ov0), .OutReady(or0),
    .OutCtrl(oc0), .OutData(od0), .Occupancy(occ0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clr1 = 0; iv1 = 0; or1 = 0; ic1 = '0; id1 = '0;
    clr0 = 0; iv0 = 0; or0 = 0; ic0 = '0; id0 = '0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    tests++;
    if (obs1 !== {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1}) begin
      failed++; $display("FAIL reset_skid1: got %h want %h", obs1, {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1});
    end
    tests++;
    if (obs0 !== {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1}) begin
      failed++; $display("FAIL reset_skid0: got %h want %h", obs0, {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1});
    end
  endtask

  task automatic test_stream;
    logic [7:0]  c;
    logic [27:0] exp;
    or1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = 8'(i);
      iv1 = 1'b1; ic1 = c; id1 = 16'h0100 + 16'(i);
      #1;
      tests++;
      if (ir1 !== 1'b1) begin
        failed++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ir1);
      end
      exp = {1'b1, c, id1, 2'd1, 1'b1};
      tick;
      tests++;
      if (obs1 !== exp) begin
        failed++; $display("FAIL stream_out[%0d]: got %h want %h", i, obs1, exp);
      end
    end
    iv1 = 1'b0;
    tick;
    tests++;
    if ({ov1, oc1, occ1, ir1} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
      failed++; $display("FAIL stream_drain: got %b/%h/%0d/%b want 0/00/0/1", ov1, oc1, occ1, ir1);
    end
  endtask

  task automatic test_backpressure;
    or1 = 1'b0;
    iv1 = 1'b1; ic1 = 8'hA1; id1 = 16'hAAAA;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'hA1, 16'hAAAA, 2'd1, 1'b1}) begin
      failed++; $display("FAIL bp_load_a: got %h want %h", obs1, {1'b1, 8'hA1, 16'hAAAA, 2'd1, 1'b1});
    end
    ic1 = 8'hB2; id1 = 16'hBBBB;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'hA1, 16'hAAAA, 2'd2, 1'b0}) begin
      failed++; $display("FAIL bp_full: got %h want %h", obs1, {1'b1, 8'hA1, 16'hAAAA, 2'd2, 1'b0});
    end
    ic1 = 8'hC3; id1 = 16'hCCCC;
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++;
      if (obs1 !== {1'b1, 8'hA1, 16'hAAAA, 2'd2, 1'b0}) begin
        failed++; $display("FAIL bp_hold[%0d]: got %h want %h", k, obs1, {1'b1, 8'hA1, 16'hAAAA, 2'd2, 1'b0});
      end
    end
    or1 = 1'b1;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'hB2, 16'hBBBB, 2'd1, 1'b1}) begin
      failed++; $display("FAIL bp_release_b: got %h want %h", obs1, {1'b1, 8'hB2, 16'hBBBB, 2'd1, 1'b1});
    end
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'hC3, 16'hCCCC, 2'd1, 1'b1}) begin
      failed++; $display("FAIL bp_c: got %h want %h", obs1, {1'b1, 8'hC3, 16'hCCCC, 2'd1, 1'b1});
    end
    iv1 = 1'b0;
    tick;
    tests++;
    if ({ov1, oc1, occ1, ir1} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
      failed++; $display("FAIL bp_drain: got %b/%h/%0d/%b want 0/00/0/1", ov1, oc1, occ1, ir1);
    end
  endtask

  task automatic test_flush;
    or1 = 1'b0;
    iv1 = 1'b1; ic1 = 8'hE5; id1 = 16'hEEEE;
    tick;
    ic1 = 8'hF6; id1 = 16'hFFFF;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'hE5, 16'hEEEE, 2'd2, 1'b0}) begin
      failed++; $display("FAIL flush_fill: got %h want %h", obs1, {1'b1, 8'hE5, 16'hEEEE, 2'd2, 1'b0});
    end
    ic1 = 8'hD4; id1 = 16'hDDDD; clr1 = 1'b1;
    tick;
    tests++;
    if (obs1 !== {1'b0, 8'h00, 16'hEEEE, 2'd0, 1'b1}) begin
      failed++; $display("FAIL flush_full: got %h want %h", obs1, {1'b0, 8'h00, 16'hEEEE, 2'd0, 1'b1});
    end
    clr1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    tick;
    tests++;
    if ({ov1, oc1, occ1} !== {1'b0, 8'h00, 2'd0}) begin
      failed++; $display("FAIL flush_no_d: got %b/%h/%0d want 0/00/0", ov1, oc1, occ1);
    end
    or1 = 1'b0;
    iv1 = 1'b1; ic1 = 8'h17; id1 = 16'h1717;
    tick;
    ic1 = 8'h2D; id1 = 16'h2D2D; clr1 = 1'b1;
    tick;
    tests++;
    if (obs1 !== {1'b0, 8'h00, 16'h1717, 2'd0, 1'b1}) begin
      failed++; $display("FAIL flush_busy_drop: got %h want %h", obs1, {1'b0, 8'h00, 16'h1717, 2'd0, 1'b1});
    end
    clr1 = 1'b0; iv1 = 1'b0;
    tick;
    tests++;
    if ({ov1, oc1, occ1} !== {1'b0, 8'h00, 2'd0}) begin
      failed++; $display("FAIL flush_busy_after: got %b/%h/%0d want 0/00/0", ov1, oc1, occ1);
    end
  endtask

  task automatic test_reset_clr;
    or1 = 1'b1;
    iv1 = 1'b1; ic1 = 8'h48; id1 = 16'h4848;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'h48, 16'h4848, 2'd1, 1'b1}) begin
      failed++; $display("FAIL rc_load: got %h want %h", obs1, {1'b1, 8'h48, 16'h4848, 2'd1, 1'b1});
    end
    rst = 1'b1; clr1 = 1'b1; ic1 = 8'h4A; id1 = 16'h4A4A;
    tick;
    tests++;
    if (obs1 !== {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1}) begin
      failed++; $display("FAIL rc_cleared: got %h want %h", obs1, {1'b0, 8'h00, 16'h0000, 2'd0, 1'b1});
    end
    rst = 1'b0; clr1 = 1'b0; ic1 = 8'h4B; id1 = 16'h4B4B;
    tick;
    tests++;
    if (obs1 !== {1'b1, 8'h4B, 16'h4B4B, 2'd1, 1'b1}) begin
      failed++; $display("FAIL rc_first_after: got %h want %h", obs1, {1'b1, 8'h4B, 16'h4B4B, 2'd1, 1'b1});
    end
    iv1 = 1'b0;
    tick;
  endtask

  task automatic test_noskid;
    logic       mv, exp_rdy, in_f, out_f;
    logic [7:0] head, nxt;
    mv = 1'b0; head = '0; nxt = 8'h00;
    for (int k = 0; k < 12; k++) begin
      or0 = (k % 2 == 0);
      iv0 = 1'b1; ic0 = nxt; id0 = {8'h50, nxt};
      #1;
      exp_rdy = or0 | ~mv;
      tests++;
      if (ir0 !== exp_rdy) begin
        failed++; $display("FAIL noskid_ready[%0d]: got %b want %b", k, ir0, exp_rdy);
      end
      in_f  = exp_rdy;
      out_f = mv & or0;
      tick;
      if (in_f) begin
        mv = 1'b1; head = nxt; nxt = nxt + 8'd1;
      end else if (out_f) begin
        mv = 1'b0;
      end
      tests++;
      if ({ov0, oc0, od0, occ0} !== {1'b1, head, 8'h50, head, 2'd1}) begin
        failed++; $display("FAIL noskid_out[%0d]: got %b/%h/%h/%0d want 1/%h/50%h/1", k, ov0, oc0, od0, occ0, head, head);
      end
    end
    iv0 = 1'b0; or0 = 1'b1;
    tick;
    tests++;
    if ({ov0, oc0, occ0, ir0} !== {1'b0, 8'h00, 2'd0, 1'b1}) begin
      failed++; $display("FAIL noskid_drain: got %b/%h/%0d/%b want 0/00/0/1", ov0, oc0, occ0, ir0);
    end
  endtask

  task automatic test_random;
    ent_t q1[$], q0[$];
    logic ev1, ev0, r1, r0, in1, in0, out1, out0;
    logic [7:0] ec1, ec0;
    rst = 1'b1; clr1 = 0; clr0 = 0; iv1 = 0; iv0 = 0;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      iv1 = ($urandom_range(0, 3) != 0); or1 = ($urandom_range(0, 2) != 0);
      ic1 = 8'($urandom); id1 = 16'($urandom); clr1 = ($urandom_range(0, 63) == 0);
      iv0 = ($urandom_range(0, 3) != 0); or0 = ($urandom_range(0, 2) != 0);
      ic0 = 8'($urandom); id0 = 16'($urandom); clr0 = ($urandom_range(0, 63) == 0);
      #1;
      ev1 = (q1.size() != 0); ec1 = ev1 ? q1[0].c : 8'h00; r1 = (q1.size() < 2);
      ev0 = (q0.size() != 0); ec0 = ev0 ? q0[0].c : 8'h00; r0 = or0 | ~ev0;
      tests++;
      if ({ov1, oc1, occ1, ir1} !== {ev1, ec1, 2'(q1.size()), r1} || (ev1 && od1 !== q1[0].d)) begin
        failed++; $display("FAIL rand_skid1[%0d]: got %b/%h/%h/%0d/%b want %b/%h/%0d/%b", k, ov1, oc1, od1, occ1, ir1, ev1, ec1, q1.size(), r1);
      end
      tests++;
      if ({ov0, oc0, occ0, ir0} !== {ev0, ec0, 2'(q0.size()), r0} || (ev0 && od0 !== q0[0].d)) begin
        failed++; $display("FAIL rand_skid0[%0d]: got %b/%h/%h/%0d/%b want %b/%h/%0d/%b", k, ov0, oc0, od0, occ0, ir0, ev0, ec0, q0.size(), r0);
      end
      in1 = iv1 & r1; out1 = ev1 & or1;
      in0 = iv0 & r0; out0 = ev0 & or0;
      tick;
      if (clr1) q1.delete();
      else begin
        if (out1) void'(q1.pop_front());
        if (in1) q1.push_back({ic1, id1});
      end
      if (clr0) q0.delete();
      else begin
        if (out0) void'(q0.pop_front());
        if (in0) q0.push_back({ic0, id0});
      end
    end
    clr1 = 0; clr0 = 0; iv1 = 0; iv0 = 0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_reset_clr;
    test_noskid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
